alu_issue_scheduler: RTL
========================

# alu_issue_scheduler

Round-robin issue scheduler between the ALU reservation station (RS) and the single-cycle ALU. Each cycle it picks one ready, not-already-in-flight RS entry, registers its operands and opcode onto the ALU input bus, and tracks the entry as in flight until the ALU's `to_rs` completion returns. It also handles global pipeline flush (`clear`) and `rdy_in` stalls.

## Interface
- `RS_WIDTH`, default 2: RS index width; `RS_SIZE = 2**RS_WIDTH` entries.
- `clk_in  in  1`: clock.
- `rst_in  in  1`: reset, asynchronous, active-low.
- `rdy_in  in  1`: global ready; low freezes state.
- `clear  in  1`: flush; acted on only when `rdy_in` is high.
- `hold  in  1`: downstream back-pressure; blocks new issue.
- `rs_ready  in  RS_SIZE`: entry has both operands and is waiting.
- `rs_vj  in  RS_SIZE*32`: operand a per entry; entry i at bits `[32i+31:32i]`.
- `rs_vk  in  RS_SIZE*32`: operand b per entry.
- `rs_op  in  RS_SIZE*4`: 4-bit ALU opcode per entry.
- `alu_done  in  1`: ALU `to_rs`.
- `alu_done_index  in  RS_WIDTH`: ALU `to_rs_index`.
- `cal  out  1`: ALU compute strobe (registered).
- `a`, `b`  out  32 each: ALU operands (registered).
- `alu_op  out  4`: ALU opcode (registered).
- `from_rs_index  out  RS_WIDTH`: issued entry index (registered).
- `grant  out  RS_SIZE`: one-hot copy of the issued entry, valid while `cal` is high.
- `issue_count  out  32`: issues since reset or flush. Wraps modulo 2^32.

## Operation
- States: RUN, FLUSH.
  - Reset enters RUN.
  - `rdy_in & clear` enters FLUSH from either state.
  - FLUSH always goes to RUN after one cycle, unless `clear` is reasserted.
- `pending[RS_SIZE]` register marks entries that are in flight.
  - At issue: set bit `idx`.
  - When `alu_done` is high: clear bit `alu_done_index`.
  - If both happen in the same cycle on different indices, apply both.
- Eligibility: `elig = rs_ready & ~pending`, using registered `pending`.
  - An entry completing this cycle is therefore not eligible this cycle.
- Issue occurs when: state is RUN, `rdy_in` is high, `clear` is low, `hold` is low, and `elig` is nonzero.
- Selection: first set bit of `elig`, scanning upward from `ptr` with wrap-around. After an issue, `ptr <= idx+1` (mod `RS_SIZE`).
- On issue, register:
  - `cal <= 1`
  - `a <= rs_vj[idx]`, `b <= rs_vk[idx]`, `alu_op <= rs_op[idx]`
  - `from_rs_index <= idx`, `grant <= 1<<idx`
  - `issue_count += 1`
- No issue, with `rdy_in` high: `cal <= 0`, `grant <= 0`. Operand and opcode registers hold their values.
- `rdy_in` low: `cal <= 0` and `grant <= 0`. All other state (`pending`, `ptr`, FSM, counter) is frozen, and `alu_done` is ignored.
- Flush (`rdy_in & clear`): `cal`, `grant`, `pending`, `ptr`, `issue_count` all go to 0. `clear` has priority over issue and over `alu_done`.
- Opcode is passed through unchecked. Values 4'b1111 and above the defined set are still issued.

## Timing
- Reset values:
  - `cal = 0`, `grant = 0`
  - `a = 0`, `b = 0`, `alu_op = 0`, `from_rs_index = 0`
  - `issue_count = 0`, `pending = 0`, `ptr = 0`, state RUN
- Issue latency: entry ready in cycle N, so `cal` and operands are visible in N+1. The ALU result and `alu_done` follow in N+2. `pending` clears at the end of N+2. The same entry is eligible again from N+3.
- Throughput: one issue per cycle across different entries. A single entry can issue at most once per 3 cycles.
- `hold` acts in the same cycle: `hold` high in cycle N means `cal` is 0 in N+1.
- Flush in cycle N: `cal` is 0 in N+1 and FLUSH is the state in N+1. The first possible issue is visible in N+3.
- Asynchronous reset mid-issue forces all outputs to their reset values immediately.

## Structure
- Shared package `alu_pkg` holds:
  - the 4-bit ALU opcode constants ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, BEQ, BGE, BGEU, BNE, ADD_PC (0x0 to 0xE);
  - the default `RS_WIDTH`;
  - the state encoding.
- Sub-module `rr_picker`: combinational. Inputs `req`, `ptr`. Outputs `found`, `idx`, one-hot.

## Test plan
- **Single issue:** reset, then `rs_ready=4'b0100`, `rs_vj[2]=5`, `rs_vk[2]=7`, op ADD.
  - Next cycle: `cal=1`, `a=5`, `b=7`, `from_rs_index=2`, `grant=4'b0100`, `issue_count=1`.
  - Entry 2 is not reissued until `alu_done` with index 2 has been seen.
- **Round-robin:** `rs_ready=4'b1111` held, with `alu_done` echoed 1 cycle after each `cal`.
  - Issue order is 0, 1, 2, 3, 0.
- **Hold:** `hold=1` for 3 cycles with entries ready.
  - `cal=0` throughout. Issue resumes the cycle after `hold` falls, at the saved `ptr`.
- **Flush:** `clear=1` the cycle after an issue of entry 1.
  - `pending=0`, `issue_count=0`, `cal=0` for 2 cycles, then entry 0 issues first.
- **rdy_in stall:** drop `rdy_in` for 2 cycles mid-stream.
  - `cal=0`. `pending`, `ptr` and `issue_count` are unchanged, and `alu_done` is ignored during the stall.
- **Simultaneous events:** `alu_done` for index 3 in the same cycle as issue of index 0.
  - `pending` becomes `4'b0001`. Index 3 is not eligible that cycle, and is eligible the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, default RS sizing, scheduler state.
package alu_pkg;

  localparam int RS_WIDTH_DEF = 2;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_SLL    = 4'h5;
  localparam logic [3:0] ALU_SRL    = 4'h6;
  localparam logic [3:0] ALU_SRA    = 4'h7;
  localparam logic [3:0] ALU_SLT    = 4'h8;
  localparam logic [3:0] ALU_SLTU   = 4'h9;
  localparam logic [3:0] ALU_BEQ    = 4'hA;
  localparam logic [3:0] ALU_BGE    = 4'hB;
  localparam logic [3:0] ALU_BGEU   = 4'hC;
  localparam logic [3:0] ALU_BNE    = 4'hD;
  localparam logic [3:0] ALU_ADD_PC = 4'hE;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } sched_state_e;

endpackage

// File: rtl/alu_issue_scheduler_rr_picker.sv
// Round-robin picker: first set bit of req scanning upward from ptr, with wrap.
module rr_picker #(
  parameter int W = 2,
  localparam int N = 2**W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  logic [W-1:0] j;

  // Walk N positions starting at ptr; index arithmetic wraps since N is 2**W.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      j = ptr + k[W-1:0];
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue from the ALU reservation station onto the registered ALU
// input bus, with in-flight tracking, flush and global-stall handling.
module alu_issue_scheduler
  import alu_pkg::*;
#(
  parameter int RS_WIDTH = RS_WIDTH_DEF,
  localparam int RS_SIZE = 2**RS_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic                  hold,
  input  logic [RS_SIZE-1:0]    rs_ready,
  input  logic [RS_SIZE*32-1:0] rs_vj,
  input  logic [RS_SIZE*32-1:0] rs_vk,
  input  logic [RS_SIZE*4-1:0]  rs_op,
  input  logic                  alu_done,
  input  logic [RS_WIDTH-1:0]   alu_done_index,
  output logic                  cal,
  output logic [31:0]           a,
  output logic [31:0]           b,
  output logic [3:0]            alu_op,
  output logic [RS_WIDTH-1:0]   from_rs_index,
  output logic [RS_SIZE-1:0]    grant,
  output logic [31:0]           issue_count
);

  sched_state_e state, state_nx;

  logic [RS_SIZE-1:0]        pending;
  logic [RS_WIDTH-1:0]       ptr;
  logic [RS_SIZE-1:0]        elig;
  logic [RS_SIZE-1:0]        done_mask;
  logic                      pick_found;
  logic [RS_WIDTH-1:0]       pick_idx;
  logic [RS_SIZE-1:0]        pick_oh;
  logic                      issue;

  // Per-entry views of the flat RS buses; entry i sits at the low end for i=0.
  logic [RS_SIZE-1:0][31:0]  vj_arr;
  logic [RS_SIZE-1:0][31:0]  vk_arr;
  logic [RS_SIZE-1:0][3:0]   op_arr;

  assign vj_arr = rs_vj;
  assign vk_arr = rs_vk;
  assign op_arr = rs_op;

  // Entries still in flight are excluded; completion this cycle does not help yet.
  assign elig = rs_ready & ~pending;

  rr_picker #(.W(RS_WIDTH)) u_pick (
    .req    (elig),
    .ptr    (ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ST_RUN;
    else         state <= state_nx;
  end

  // Next state: clear wins from anywhere, FLUSH lasts one cycle, stall freezes.
  always_comb begin
    state_nx = state;
    if (rdy_in) begin
      if (clear) state_nx = ST_FLUSH;
      else       state_nx = ST_RUN;
    end
  end

  // Issue decision for this cycle.
  always_comb begin
    issue = 1'b0;
    if (state == ST_RUN && rdy_in && !clear && !hold && pick_found) issue = 1'b1;
  end

  // Decode the completion index into a clear mask.
  always_comb begin
    done_mask = '0;
    if (alu_done) done_mask[alu_done_index] = 1'b1;
  end

  // In-flight tracking: set on issue, clear on completion, wiped by flush.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pending <= '0;
    end else if (rdy_in) begin
      if (clear)      pending <= '0;
      else if (issue) pending <= (pending & ~done_mask) | pick_oh;
      else            pending <= pending & ~done_mask;
    end
  end

  // ALU input bus, round-robin pointer and issue counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cal           <= 1'b0;
      grant         <= '0;
      a             <= '0;
      b             <= '0;
      alu_op        <= '0;
      from_rs_index <= '0;
      ptr           <= '0;
      issue_count   <= '0;
    end else if (!rdy_in) begin
      cal   <= 1'b0;
      grant <= '0;
    end else if (clear) begin
      cal         <= 1'b0;
      grant       <= '0;
      ptr         <= '0;
      issue_count <= '0;
    end else if (issue) begin
      cal           <= 1'b1;
      grant         <= pick_oh;
      a             <= vj_arr[pick_idx];
      b             <= vk_arr[pick_idx];
      alu_op        <= op_arr[pick_idx];
      from_rs_index <= pick_idx;
      ptr           <= pick_idx + 1'b1;
      issue_count   <= issue_count + 32'd1;
    end else begin
      cal   <= 1'b0;
      grant <= '0;
    end
  end

endmodule
